// File: rtl/mdio_master_ctrl.sv
// mdio_master_ctrl: clause-22 MDIO/MDC station-management master.
// Takes one register read or write at a time, sends a preamble and a 32-bit
// frame on MDC/MDIO, and returns read data with a one-cycle completion pulse.
// Optional feature macro: MDIO_TA_CHECK_EN. When it is defined, a read samples
// the second turnaround bit. A '1' there means no PHY is responding, so the
// read reports rsp_err=1 with rsp_rdata=16'hFFFF.
module mdio_master_ctrl #(
    parameter int CLK_DIV      = 10,
    parameter int PREAMBLE_LEN = 32
) (
    input  logic        wb_clk_i,
    input  logic        wb_rst_i,
    input  logic        cmd_valid,
    output logic        cmd_ready,
    input  logic        cmd_write,
    input  logic [4:0]  cmd_phy_addr,
    input  logic [4:0]  cmd_reg_addr,
    input  logic [15:0] cmd_wdata,
    output logic        rsp_valid,
    output logic [15:0] rsp_rdata,
    output logic        rsp_err,
    output logic        busy,
    output logic        mdc,
    output logic        mdio_o,
    output logic        mdio_oe,
    input  logic        mdio_i
);
    localparam int NBITS = PREAMBLE_LEN + 32;
    localparam int DIV_W = $clog2(CLK_DIV);
    localparam int BIT_W = $clog2(NBITS);

    localparam logic [1:0] S_IDLE  = 2'd0;
    localparam logic [1:0] S_PRE   = 2'd1;
    localparam logic [1:0] S_FRAME = 2'd2;
    localparam logic [1:0] S_DONE  = 2'd3;

    logic [1:0]       state;
    logic [DIV_W-1:0] div_cnt;
    logic [BIT_W-1:0] bit_cnt;
    logic [31:0]      tx_frame;
    logic             is_read;
    logic [15:0]      rx_sr;
    logic [BIT_W-1:0] nxt_idx;
    logic [1:0]       nxt_drv;
    logic [4:0]       cur_fi;
    logic             phase_end;
    logic             accept;
    logic             sample;

`ifdef MDIO_TA_CHECK_EN
    logic             ta_bit;
    logic             err_q;
    assign rsp_err = err_q;
`else
    assign rsp_err = 1'b0;
`endif

    // {oe, o} for a given bit index: preamble ones, then the latched frame;
    // a read releases the bus from the first turnaround bit onwards.
    function automatic logic [1:0] bit_drive(input logic [BIT_W-1:0] idx,
                                             input logic [31:0] frame,
                                             input logic rd);
        logic [4:0] fi;
        if (idx < BIT_W'(PREAMBLE_LEN)) return 2'b11;
        fi = 5'(idx - BIT_W'(PREAMBLE_LEN));
        if (rd && (fi >= 5'd14)) return 2'b01;
        return {1'b1, frame[5'd31 - fi]};
    endfunction

    assign cmd_ready = (state == S_IDLE);
    assign busy      = (state != S_IDLE);
    assign rsp_valid = (state == S_DONE);
    assign accept    = cmd_ready & cmd_valid;
    assign phase_end = (div_cnt == DIV_W'(CLK_DIV - 1));
    assign sample    = (state == S_FRAME) & phase_end & ~mdc;
    assign nxt_idx   = bit_cnt + BIT_W'(1);
    assign nxt_drv   = bit_drive(nxt_idx, tx_frame, is_read);
    assign cur_fi    = 5'(bit_cnt - BIT_W'(PREAMBLE_LEN));

    // Command latch and read-data capture (datapath, no reset needed)
    always_ff @(posedge wb_clk_i) begin
        if (accept) begin
            is_read  <= ~cmd_write;
            tx_frame <= {2'b01, (cmd_write ? 2'b01 : 2'b10), cmd_phy_addr, cmd_reg_addr,
                         (cmd_write ? 2'b10 : 2'b11), (cmd_write ? cmd_wdata : 16'hFFFF)};
        end
        if (sample && (cur_fi >= 5'd16)) rx_sr <= {rx_sr[14:0], mdio_i};
`ifdef MDIO_TA_CHECK_EN
        if (sample && (cur_fi == 5'd15)) ta_bit <= mdio_i;
`endif
    end

    // Sequencer: divider, bit counter, MDC/MDIO drive and completion
    always_ff @(posedge wb_clk_i) begin
        if (wb_rst_i) begin
            state     <= S_IDLE;
            div_cnt   <= '0;
            bit_cnt   <= '0;
            mdc       <= 1'b0;
            mdio_o    <= 1'b1;
            mdio_oe   <= 1'b0;
            rsp_rdata <= 16'h0000;
`ifdef MDIO_TA_CHECK_EN
            err_q     <= 1'b0;
`endif
        end else begin
            case (state)
                S_IDLE: begin
                    mdc     <= 1'b0;
                    mdio_oe <= 1'b0;
                    if (cmd_valid) begin
                        state   <= S_PRE;
                        div_cnt <= '0;
                        bit_cnt <= '0;
                        mdio_o  <= 1'b1;
                        mdio_oe <= 1'b1;
                    end
                end
                S_PRE, S_FRAME: begin
                    if (!phase_end) begin
                        div_cnt <= div_cnt + DIV_W'(1);
                    end else begin
                        div_cnt <= '0;
                        if (!mdc) begin
                            mdc <= 1'b1;
                        end else begin
                            mdc <= 1'b0;
                            if (bit_cnt == BIT_W'(NBITS - 1)) begin
                                state   <= S_DONE;
                                mdio_o  <= 1'b1;
                                mdio_oe <= 1'b0;
                                if (is_read) begin
`ifdef MDIO_TA_CHECK_EN
                                    err_q     <= ta_bit;
                                    rsp_rdata <= ta_bit ? 16'hFFFF : rx_sr;
`else
                                    rsp_rdata <= rx_sr;
`endif
                                end else begin
`ifdef MDIO_TA_CHECK_EN
                                    err_q <= 1'b0;
`endif
                                end
                            end else begin
                                bit_cnt           <= nxt_idx;
                                {mdio_oe, mdio_o} <= nxt_drv;
                                if (nxt_idx == BIT_W'(PREAMBLE_LEN)) state <= S_FRAME;
                            end
                        end
                    end
                end
                S_DONE: begin
                    state <= S_IDLE;
                end
                default: begin
                    state <= S_IDLE;
                end
            endcase
        end
    end
endmodule
